// File: rtl/dma_pkg.sv
// Shared types and helpers for the DMA read/write engines.
package dma_pkg;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} t_dma_wr_state;

  localparam int unsigned CL_DATA_W  = 512;
  localparam int unsigned DMA_ADDR_W = 42;

  // Lines acknowledged by one CCI-P response; packed responses carry count-1.
  function automatic logic [2:0] rsp_lines(input logic format, input logic [1:0] cl_num);
    return format ? ({1'b0, cl_num} + 3'd1) : 3'd1;
  endfunction

endpackage

// File: rtl/wr_line_fifo.sv
// Synchronous line FIFO with registered read data (held between pops).
module wr_line_fifo
  import dma_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = CL_DATA_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          pop_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_B = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      pop_data <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr   <= rd_ptr + PTR_W'(1);
        pop_data <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_B'(1);
        2'b01:   count <= count - CNT_B'(1);
        default: ;
      endcase
    end
  end

  assign full  = (count == CNT_B'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/dma_write_engine.sv
// Streams 512-bit words to consecutive cache lines as CCI-P WrLine_I requests
// and counts (possibly packed) write responses until all are acknowledged.
module dma_write_engine
  import dma_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ADDR_W     = DMA_ADDR_W,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    dst_addr,
  input  logic [CNT_W-1:0]     dst_ncl,
  input  logic [511:0]         in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic                 c1tx_valid,
  output logic [ADDR_W-1:0]    c1tx_addr,
  output logic [511:0]         c1tx_data,
  output logic [15:0]          c1tx_mdata,
  input  logic                 c1_alm_full,
  input  logic                 c1rx_rsp_valid,
  input  logic                 c1rx_format,
  input  logic [1:0]           c1rx_cl_num,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     lines_written,
  output logic                 overflow
);

  t_dma_wr_state state_q, state_d;

  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  limit_q;
  logic [CNT_W-1:0]  acc_cnt;
  logic [CNT_W-1:0]  req_cnt;
  logic [CNT_W-1:0]  rsp_cnt;

  logic                        fifo_full;
  logic                        fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  logic accept, push, pop, start_ok, rsp_active;

  assign in_ready   = (state_q == STREAM) && !fifo_full;
  assign accept     = in_valid && in_ready;
  assign push       = accept && (acc_cnt < limit_q);
  assign pop        = !fifo_empty && !c1_alm_full;
  assign start_ok   = start && ((state_q == IDLE) || (state_q == DONE));
  // Responses only count while a transfer is live, so stragglers after reset are ignored.
  assign rsp_active = (state_q == STREAM) || (state_q == DRAIN);

  assign busy          = (state_q == STREAM) || (state_q == DRAIN);
  assign done          = (state_q == DONE);
  assign lines_written = rsp_cnt;

  wr_line_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (CL_DATA_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .pop_data  (c1tx_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = STREAM;
      STREAM:  if (accept && in_last) state_d = DRAIN;
      DRAIN:   if ((fifo_count == '0) && !c1tx_valid && (rsp_cnt == req_cnt)) state_d = DONE;
      DONE:    if (start) state_d = STREAM;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base_q   <= '0;
      limit_q  <= '0;
      acc_cnt  <= '0;
      req_cnt  <= '0;
      rsp_cnt  <= '0;
      overflow <= 1'b0;
    end else if (start_ok) begin
      base_q   <= dst_addr;
      limit_q  <= dst_ncl;
      acc_cnt  <= '0;
      req_cnt  <= '0;
      rsp_cnt  <= '0;
      overflow <= 1'b0;
    end else begin
      if (push)                  acc_cnt  <= acc_cnt + CNT_W'(1);
      if (accept && !push)       overflow <= 1'b1;
      if (pop)                   req_cnt  <= req_cnt + CNT_W'(1);
      if (c1rx_rsp_valid && rsp_active)
        rsp_cnt <= rsp_cnt + CNT_W'(rsp_lines(c1rx_format, c1rx_cl_num));
    end
  end

  // Request fields register alongside the FIFO's registered read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      c1tx_valid <= 1'b0;
      c1tx_addr  <= '0;
      c1tx_mdata <= '0;
    end else begin
      c1tx_valid <= pop;
      if (pop) begin
        c1tx_addr  <= base_q + ADDR_W'(req_cnt);
        c1tx_mdata <= req_cnt[15:0];
      end
    end
  end

endmodule

// File: tb/tb_dma_write_engine.sv
// Self-checking bench for dma_write_engine against a line-list reference model.
module tb_dma_write_engine;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [41:0]  dst_addr = '0;
  logic [31:0]  dst_ncl = '0;
  logic [511:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic         in_ready;
  logic         c1tx_valid;
  logic [41:0]  c1tx_addr;
  logic [511:0] c1tx_data;
  logic [15:0]  c1tx_mdata;
  logic         c1_alm_full = 1'b0;
  logic         c1rx_rsp_valid = 1'b0;
  logic         c1rx_format = 1'b0;
  logic [1:0]   c1rx_cl_num = '0;
  logic         busy;
  logic         done;
  logic [31:0]  lines_written;
  logic         overflow;

  always #5 clk = ~clk;

  dma_write_engine #(.FIFO_DEPTH(16), .ADDR_W(42), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .dst_addr(dst_addr), .dst_ncl(dst_ncl),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .c1tx_valid(c1tx_valid), .c1tx_addr(c1tx_addr), .c1tx_data(c1tx_data),
    .c1tx_mdata(c1tx_mdata), .c1_alm_full(c1_alm_full), .c1rx_rsp_valid(c1rx_rsp_valid),
    .c1rx_format(c1rx_format), .c1rx_cl_num(c1rx_cl_num), .busy(busy), .done(done),
    .lines_written(lines_written), .overflow(overflow)
  );

  typedef struct {
    logic [41:0]  addr;
    logic [511:0] data;
    logic [15:0]  mdata;
  } exp_t;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned writes_seen = 0;
  int unsigned w_start = 0;
  exp_t        exp_q[$];
  logic [41:0] m_base;
  int unsigned m_ncl, m_acc, m_rsp;
  logic        m_ovf;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && c1tx_valid) begin
      exp_t e;
      writes_seen++;
      if (exp_q.size() == 0) chk("unexpected_write", c1tx_valid, 1'b0);
      else begin
        e = exp_q.pop_front();
        chk("wr_addr", c1tx_addr, e.addr);
        chk("wr_data", c1tx_data, e.data);
        chk("wr_mdata", c1tx_mdata, e.mdata);
      end
    end
  end

  task automatic do_start(input logic [41:0] base, input int unsigned ncl, input bit model);
    dst_addr = base; dst_ncl = ncl; start = 1'b1;
    if (model) begin
      m_base = base; m_ncl = ncl; m_acc = 0; m_rsp = 0; m_ovf = 1'b0;
      w_start = writes_seen;
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_words(input int unsigned n, input bit last_at_end, input int unsigned max_gap);
    logic [511:0] d;
    int unsigned tmo, g;
    for (int unsigned i = 0; i < n; i++) begin
      for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom();
      in_data = d; in_valid = 1'b1; in_last = last_at_end && (i == n - 1);
      @(negedge clk);
      tmo = 0;
      while (!in_ready && tmo < 200) begin @(negedge clk); tmo++; end
      if (tmo >= 200) begin
        chk("in_ready_timeout", in_ready, 1'b1);
        in_valid = 1'b0; in_last = 1'b0;
        return;
      end
      if (m_acc < m_ncl) exp_q.push_back('{m_base + 42'(m_acc), d, 16'(m_acc)});
      else               m_ovf = 1'b1;
      m_acc++;
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
      g = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
      if (g > 0) begin repeat (g) @(posedge clk); #1; end
    end
  endtask

  task automatic send_rsp(input logic fmt, input logic [1:0] cl);
    c1rx_rsp_valid = 1'b1; c1rx_format = fmt; c1rx_cl_num = cl;
    m_rsp += fmt ? int'(cl) + 1 : 1;
    @(posedge clk); #1;
    c1rx_rsp_valid = 1'b0; c1rx_format = 1'b0; c1rx_cl_num = '0;
  endtask

  task automatic wait_writes();
    int unsigned total, tmo;
    total = (m_acc < m_ncl) ? m_acc : m_ncl;
    tmo = 0;
    while (writes_seen < w_start + total && tmo < 300) begin @(negedge clk); tmo++; end
    repeat (3) @(negedge clk);
    chk("write_count", writes_seen - w_start, total);
    chk("exp_drained", exp_q.size(), 0);
    chk("overflow", overflow, m_ovf);
  endtask

  task automatic wait_done_and_check();
    int unsigned tmo = 0;
    while (done !== 1'b1 && tmo < 20) begin @(negedge clk); tmo++; end
    chk("done", done, 1'b1);
    chk("busy_done", busy, 1'b0);
    chk("lines_written", lines_written, m_rsp);
  endtask

  task automatic respond_random(input int unsigned total);
    int unsigned rem, k;
    rem = total;
    while (rem > 0) begin
      k = $urandom_range(1, (rem < 4) ? rem : 4);
      if (k == 1 && $urandom_range(0, 1) == 0) send_rsp(1'b0, 2'd0);
      else                                     send_rsp(1'b1, 2'(k - 1));
      rem -= k;
      if (rem > 0) begin @(negedge clk); chk("done_early", done, 1'b0); end
    end
  endtask

  initial begin
    int unsigned n0, tmo, nw, nc;
    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", c1tx_valid, 1'b0);   chk("rst_ready", in_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);          chk("rst_done", done, 1'b0);
    chk("rst_ovf", overflow, 1'b0);       chk("rst_lines", lines_written, 0);
    chk("rst_addr", c1tx_addr, 0);        chk("rst_data", c1tx_data, 0);
    chk("rst_mdata", c1tx_mdata, 0);
    @(posedge clk); #1; reset = 1'b0;

    // basic: 4 lines at 0x1000, single responses
    do_start(42'h1000, 4, 1'b1);
    chk("busy_stream", busy, 1'b1);
    send_words(4, 1'b1, 0);
    wait_writes();
    chk("done_before_rsp", done, 1'b0);
    for (int unsigned i = 0; i < 4; i++) begin
      send_rsp(1'b0, 2'd0);
      @(negedge clk);
      chk("lines_step", lines_written, i + 1);
      if (i < 3) chk("done_partial", done, 1'b0);
    end
    wait_done_and_check();

    // one packed response of four
    do_start(42'($urandom()), 4, 1'b1);
    chk("done_cleared", done, 1'b0);
    send_words(4, 1'b1, 1);
    wait_writes();
    send_rsp(1'b1, 2'd3);
    wait_done_and_check();

    // packed pair then two singles
    do_start(42'($urandom()), 4, 1'b1);
    send_words(4, 1'b1, 0);
    wait_writes();
    send_rsp(1'b1, 2'd1);
    send_rsp(1'b0, 2'd0);
    repeat (2) @(negedge clk);
    chk("done_3_of_4", done, 1'b0);
    send_rsp(1'b0, 2'd0);
    wait_done_and_check();

    // almost-full back-pressure during a burst
    do_start(42'($urandom()), 24, 1'b1);
    fork
      send_words(24, 1'b1, 0);
      begin
        tmo = 0;
        while (m_acc < 2 && tmo < 50) begin @(negedge clk); tmo++; end
        @(posedge clk); #1;
        c1_alm_full = 1'b1;
        n0 = writes_seen;
        repeat (20) @(posedge clk); #1;
        chk("alm_full_at_most_one", (writes_seen - n0) <= 1, 1'b1);
        chk("in_ready_full", in_ready, 1'b0);
        chk("buffered_16", m_acc, writes_seen - w_start + 16);
        c1_alm_full = 1'b0;
      end
    join
    wait_writes();
    respond_random(24);
    wait_done_and_check();

    // more words than lines allowed
    do_start(42'($urandom()), 2, 1'b1);
    send_words(3, 1'b1, 0);
    wait_writes();
    chk("overflow_set", overflow, 1'b1);
    send_rsp(1'b0, 2'd0);
    send_rsp(1'b0, 2'd0);
    wait_done_and_check();

    // zero-line limit
    do_start(42'h3000, 0, 1'b1);
    send_words(1, 1'b1, 0);
    wait_writes();
    wait_done_and_check();

    // start ignored mid-stream, then reset with requests outstanding
    do_start(42'h2000, 4, 1'b1);
    send_words(2, 1'b0, 0);
    do_start(42'h5555, 1, 1'b0);
    chk("busy_after_ignored_start", busy, 1'b1);
    send_words(2, 1'b1, 0);
    wait_writes();
    send_rsp(1'b0, 2'd0);
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    exp_q.delete();
    send_rsp(1'b1, 2'd1);
    send_rsp(1'b0, 2'd0);
    @(negedge clk);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_done", done, 1'b0);
    chk("rst_mid_ready", in_ready, 1'b0);
    chk("rst_mid_lines", lines_written, 0);
    chk("rst_mid_valid", c1tx_valid, 1'b0);

    // address wrap at the top of the line space
    do_start({42{1'b1}} - 42'd1, 3, 1'b1);
    send_words(3, 1'b1, 0);
    wait_writes();
    respond_random(3);
    wait_done_and_check();

    // randomized transfers
    for (int r = 0; r < 4; r++) begin
      nc = $urandom_range(1, 8);
      nw = $urandom_range(1, 10);
      do_start(42'({$urandom(), $urandom()}), nc, 1'b1);
      send_words(nw, 1'b1, 2);
      wait_writes();
      respond_random((nw < nc) ? nw : nc);
      wait_done_and_check();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    chk("global_timeout", 1'b0 ^ done, 1'b1 ^ done);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "FAIL global_timeout reached");
  end

endmodule
